mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port of the 16-bit pipelined CPU between the IF stage (instruction fetch)
//  and the MEM stage (LWD/SWD data access). Latches one request at a time, sequences it to memory and
//  returns data with a 1-cycle ack pulse. Drives per-stage stall lines to the hazard logic.
//  Sits between the pipeline datapath and the memory model.
// PARAMETERS
//  WORD_SIZE  16  data and address width, matches `WORD_SIZE
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  i_req      in   1          fetch request, held with i_addr stable until i_ack
//  i_addr     in   WORD_SIZE  fetch address
//  i_ack      out  1          1-cycle pulse: i_rdata valid
//  i_rdata    out  WORD_SIZE  fetched instruction, held until next i_ack
//  d_req      in   1          data request, held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1          1 = write (SWD), 0 = read (LWD)
//  d_addr     in   WORD_SIZE  data address
//  d_wdata    in   WORD_SIZE  store data
//  d_ack      out  1          1-cycle pulse: access done, d_rdata valid on reads
//  d_rdata    out  WORD_SIZE  load data, held until next read d_ack
//  stall_if   out  1          i_req & ~i_ack, combinational
//  stall_mem  out  1          d_req & ~d_ack, combinational
//  mem_req    out  1          memory request, held until mem_ack
//  mem_we     out  1          memory write enable
//  mem_addr   out  WORD_SIZE  memory address
//  mem_wdata  out  WORD_SIZE  memory write data
//  mem_rdata  in   WORD_SIZE  memory read data, valid with mem_ack
//  mem_ack    in   1          1-cycle completion pulse from memory, >=1 cycle after mem_req rises
// BEHAVIOUR
//  - Reset: all registered outputs 0, state IDLE, last_grant = FETCH. mem_req drops asynchronously.
//  - FSM states: IDLE, I_BUSY, D_BUSY.
//  - IDLE: if both d_req and i_req are high, data is granted unless last_grant == DATA, in which case fetch
//    is granted (alternation, no starvation). A single requester is granted directly.
//  - On grant: the request is latched into mem_* on the next edge, mem_req = 1, state -> x_BUSY,
//    last_grant updated.
//  - x_BUSY: mem_* are held stable. On mem_ack: mem_req = 0 and state -> IDLE on the same edge; x_ack is
//    pulsed the next cycle; x_rdata captures mem_rdata. Writes leave d_rdata unchanged.
//  - Minimum latency: req sampled at cycle 0, mem_req at cycle 1, mem_ack at cycle >= 2, x_ack at cycle >= 3.
//  - Back-to-back: IDLE is always visited for 1 cycle between transactions. Max throughput is 1 access per
//    3 cycles.
//  - Flush: if the owning x_req is low when mem_ack arrives, the memory access completes but x_ack is
//    suppressed and x_rdata is not updated.
//  - mem_ack in IDLE (late ack after reset) is ignored.
//  - Reset during x_BUSY aborts the transaction; no ack is produced.
//  - A requester holding req across its own ack re-arbitrates as a new request.
// CONFIGURATION
//  FETCH_BUF_EN defined:
//    - Adds a one-entry fetch buffer {valid, addr, data}, filled on every completed fetch.
//    - IDLE hit (i_req, fetch granted, valid, i_addr == addr): no memory access, i_ack + i_rdata = buffer
//      data on the next cycle, state stays IDLE.
//    - Any granted data write clears valid. Reset clears valid.
//  FETCH_BUF_EN undefined: every fetch goes to memory; no buffer logic.
// TESTING
//  1. reset pulse mid-idle -> all outputs 0, stall_* follow reqs only.
//  2. i_req addr 0x0010, mem_ack 2 cycles after mem_req with 0xABCD -> mem_we=0, mem_addr=0x0010,
//     i_ack 1 cycle later, i_rdata=0xABCD.
//  3. i_req 0x0010 + d_req write 0x1234 @0x0040 same cycle -> data first (mem_we=1, mem_wdata=0x1234),
//     then fetch. With both held, grants alternate D,I,D,I.
//  4. i_req dropped during I_BUSY -> no i_ack, i_rdata unchanged, state IDLE after mem_ack.
//  5. reset during D_BUSY -> mem_req low immediately, later mem_ack ignored, no d_ack.
//  6. FETCH_BUF_EN: fetch 0x0010 twice -> 2nd i_ack 1 cycle after req, no mem_req. Write to 0x0010,
//     fetch again -> goes to memory.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the unified memory port between the IF and MEM pipeline stages
//
// One request is served at a time. An IDLE cycle always separates two memory transactions.
// When both stages request in the same cycle, data wins unless data was granted last time,
// so neither stage can starve.
//
// Optional feature macro: FETCH_BUF_EN adds a one-entry fetch buffer that can answer a
// repeated fetch without a memory access.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   i_req/i_addr             fetch request in
//   i_ack/i_rdata            fetch completion pulse and instruction out
//   d_req/d_we/d_addr/d_wdata  data request in
//   d_ack/d_rdata            data completion pulse and load data out
//   stall_if, stall_mem      combinational stall lines to the hazard logic
//   mem_req/mem_we/mem_addr/mem_wdata  memory request out, held until mem_ack
//   mem_rdata/mem_ack        memory response in
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 stall_if,
  output logic                 stall_mem,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t               state, state_nx;
  logic                 last_data;   // 1 when the most recent grant went to the data side
  logic                 grant_d, grant_i;
  logic                 buf_hit;
  logic [WORD_SIZE-1:0] hit_data;

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

  // Data wins a tie unless it won the previous grant.
  assign grant_d = d_req & (~i_req | ~last_data);
  assign grant_i = i_req & ~grant_d;

`ifdef FETCH_BUF_EN
  logic                 buf_valid;
  logic [WORD_SIZE-1:0] buf_addr;
  logic [WORD_SIZE-1:0] buf_data;

  assign buf_hit  = grant_i & buf_valid & (i_addr == buf_addr);
  assign hit_data = buf_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (state == IDLE && grant_d && d_we) begin
      // Any store may alias the buffered instruction, so drop it.
      buf_valid <= 1'b0;
    end else if (state == I_BUSY && mem_ack) begin
      // Filled even on a flushed fetch: the data is still correct for that address.
      buf_valid <= 1'b1;
      buf_addr  <= mem_addr;
      buf_data  <= mem_rdata;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d)                 state_nx = D_BUSY;
        else if (grant_i && !buf_hit) state_nx = I_BUSY;
      end
      I_BUSY:  if (mem_ack) state_nx = IDLE;
      D_BUSY:  if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            last_data <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            last_data <= 1'b0;
            if (buf_hit) begin
              i_ack   <= 1'b1;
              i_rdata <= hit_data;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
            end
          end
        end
        I_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // A dropped request means the fetch was flushed: complete silently.
            if (i_req) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        D_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (d_req) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule
